// File: rtl/ps2_rx_frame.sv
// ============================================================================
// ps2_rx_frame
// ----------------------------------------------------------------------------
// PS/2 device-to-host receiver. The PS/2 clock and data lines are
// synchronised, and the clock is glitch-filtered. The block decodes 11-bit
// frames (start, 8 data bits LSB first, odd parity, stop) and buffers good
// bytes in a 4-entry FIFO with a valid/ready output. It only receives and
// never drives the PS/2 lines.
//
// Parameters
//   clk_freq    system clock frequency in Hz
//   filter_len  consecutive equal samples needed to accept a ps2_clk level
//   timeout_us  maximum gap between ps2_clk falling edges inside a frame
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   ps2_clk     PS/2 clock line (read only)
//   ps2_data    PS/2 data line (read only)
//   rx_data     FIFO head byte, meaningful while rx_valid=1
//   rx_valid    FIFO not empty
//   rx_ready    consumer takes the head when rx_valid && rx_ready
//   parity_err  one-cycle pulse: frame dropped because of bad parity
//   frame_err   one-cycle pulse: bad stop bit or inter-edge timeout
//   overflow    one-cycle pulse: good byte dropped because the FIFO is full
//   busy        high while a frame is being received
// ============================================================================
module ps2_rx_frame #(
    parameter int clk_freq   = 50000000,
    parameter int filter_len = 8,
    parameter int timeout_us = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overflow,
    output logic       busy
);

    localparam int TIMEOUT_CYC = (clk_freq / 1000000) * timeout_us;
    localparam int GAP_W       = $clog2(TIMEOUT_CYC + 1);

    localparam logic [GAP_W-1:0] TIMEOUT_LAST = GAP_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0]       FILT_LAST    = 8'(filter_len - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    // ------------------------------------------------------------------
    // Two-flop synchronisers. Bit 0 is the clock line and bit 1 is the
    // data line. Both reset to 1, which is the idle level of the pulled-up
    // bus.
    // ------------------------------------------------------------------
    logic [1:0] line_in;
    logic [1:0] line_sync;

    assign line_in = {ps2_data, ps2_clk};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic s1_reg;
            logic s2_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    s1_reg <= 1'b1;
                    s2_reg <= 1'b1;
                end else begin
                    s1_reg <= line_in[gi];
                    s2_reg <= s1_reg;
                end
            end

            assign line_sync[gi] = s2_reg;
        end
    endgenerate

    logic clk_sync;
    logic data_sync;

    assign clk_sync  = line_sync[0];
    assign data_sync = line_sync[1];

    // ------------------------------------------------------------------
    // Glitch filter. The filtered clock flips only after filter_len
    // consecutive synced samples that differ from its current level. Any
    // sample that agrees with the current level restarts the count.
    // ------------------------------------------------------------------
    logic [7:0] filt_cnt_reg;
    logic       clk_filt_reg;
    logic       clk_filt_prev_reg;
    logic       fall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_cnt_reg      <= 8'd0;
            clk_filt_reg      <= 1'b1;
            clk_filt_prev_reg <= 1'b1;
        end else begin
            clk_filt_prev_reg <= clk_filt_reg;
            if (clk_sync == clk_filt_reg) begin
                filt_cnt_reg <= 8'd0;
            end else if (filt_cnt_reg == FILT_LAST) begin
                clk_filt_reg <= clk_sync;
                filt_cnt_reg <= 8'd0;
            end else begin
                filt_cnt_reg <= filt_cnt_reg + 8'd1;
            end
        end
    end

    // Single-cycle strobe on a filtered 1->0 transition.
    assign fall = clk_filt_prev_reg & ~clk_filt_reg;

    // ------------------------------------------------------------------
    // Frame decoder
    // ------------------------------------------------------------------
    logic [1:0]       state_reg;
    logic [2:0]       bit_cnt_reg;
    logic [7:0]       shift_reg;
    logic             p_ok_reg;
    logic [GAP_W-1:0] gap_cnt_reg;
    logic             parity_err_reg;
    logic             frame_err_reg;
    logic             push_req;

    // A good byte is offered to the FIFO in the same cycle as the stop-bit
    // strobe, so rx_valid rises on the following clock.
    assign push_req = fall && (state_reg == ST_STOP) && data_sync && p_ok_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            bit_cnt_reg    <= 3'd0;
            shift_reg      <= 8'd0;
            p_ok_reg       <= 1'b0;
            gap_cnt_reg    <= '0;
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;

            if (fall) begin
                gap_cnt_reg <= '0;
                case (state_reg)
                    ST_IDLE: begin
                        // A high start bit is simply ignored.
                        if (!data_sync) begin
                            state_reg   <= ST_DATA;
                            bit_cnt_reg <= 3'd0;
                        end
                    end
                    ST_DATA: begin
                        shift_reg[bit_cnt_reg] <= data_sync;
                        if (bit_cnt_reg == 3'd7) begin
                            state_reg <= ST_PARITY;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        end
                    end
                    ST_PARITY: begin
                        // Odd parity: data bits plus the parity bit must
                        // contain an odd number of ones.
                        p_ok_reg  <= (^shift_reg) ^ data_sync;
                        state_reg <= ST_STOP;
                    end
                    default: begin
                        // Stop bit. A bad stop bit takes priority over a
                        // parity error.
                        state_reg <= ST_IDLE;
                        if (!data_sync) begin
                            frame_err_reg <= 1'b1;
                        end else if (!p_ok_reg) begin
                            parity_err_reg <= 1'b1;
                        end
                    end
                endcase
            end else if (state_reg != ST_IDLE) begin
                // The device stalled mid-frame. Abandon the partial byte.
                if (gap_cnt_reg == TIMEOUT_LAST) begin
                    state_reg     <= ST_IDLE;
                    frame_err_reg <= 1'b1;
                    gap_cnt_reg   <= '0;
                end else begin
                    gap_cnt_reg <= gap_cnt_reg + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // 4-entry FIFO. rx_data is a registered copy of the head entry. The
    // bypass path handles a push that lands in the slot that becomes the
    // head on this clock.
    // ------------------------------------------------------------------
    logic [7:0] mem [0:3];
    logic [1:0] wr_ptr_reg;
    logic [1:0] rd_ptr_reg;
    logic [2:0] count_reg;
    logic [7:0] rx_data_reg;
    logic       overflow_reg;
    logic       pop;
    logic       full;
    logic       do_push;
    logic       drop;
    logic [1:0] rd_ptr_next;

    assign pop         = (count_reg != 3'd0) && rx_ready;
    assign full        = (count_reg == 3'd4);
    assign do_push     = push_req && (!full || pop);
    assign drop        = push_req && full && !pop;
    assign rd_ptr_next = rd_ptr_reg + 2'(pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= shift_reg;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg   <= 2'd0;
            rd_ptr_reg   <= 2'd0;
            count_reg    <= 3'd0;
            rx_data_reg  <= 8'd0;
            overflow_reg <= 1'b0;
        end else begin
            overflow_reg <= drop;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_reg + 3'(do_push) - 3'(pop);
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 2'd1;
            end
            if (do_push && (wr_ptr_reg == rd_ptr_next)) begin
                rx_data_reg <= shift_reg;
            end else begin
                rx_data_reg <= mem[rd_ptr_next];
            end
        end
    end

    assign rx_data    = rx_data_reg;
    assign rx_valid   = (count_reg != 3'd0);
    assign parity_err = parity_err_reg;
    assign frame_err  = frame_err_reg;
    assign overflow   = overflow_reg;
    assign busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_ps2_rx_frame.sv
// ============================================================================
// tb_ps2_rx_frame
// ----------------------------------------------------------------------------
// Self-checking bench for ps2_rx_frame. The system clock parameter is scaled
// to 1 MHz so that one clock cycle is 1 us. A 20-cycle half-period models the
// PS/2 clock, and the timeout is 400 cycles.
// ============================================================================
module tb_ps2_rx_frame;

    localparam int CLK_FREQ   = 1000000;
    localparam int FILTER_LEN = 4;
    localparam int TIMEOUT_US = 400;

    logic       clk        = 1'b0;
    logic       rst        = 1'b0;
    logic       ps2_clk    = 1'b1;
    logic       ps2_data   = 1'b1;
    logic       rdy_manual = 1'b0;
    logic       rdy_rand   = 1'b0;
    logic       rand_mode  = 1'b0;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       overflow;
    logic       busy;

    assign rx_ready = rand_mode ? rdy_rand : rdy_manual;

    int checks   = 0;
    int errors   = 0;
    int par_cnt  = 0;
    int frm_cnt  = 0;
    int ovf_cnt  = 0;
    int half_cyc = 20;
    int got_rd   = 0;
    logic [7:0] got_q[$];

    ps2_rx_frame #(
        .clk_freq   (CLK_FREQ),
        .filter_len (FILTER_LEN),
        .timeout_us (TIMEOUT_US)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #10 clk = ~clk;

    // Monitor: count pulse cycles and log every accepted byte.
    always @(negedge clk) begin
        if (parity_err) par_cnt <= par_cnt + 1;
        if (frame_err)  frm_cnt <= frm_cnt + 1;
        if (overflow)   ovf_cnt <= ovf_cnt + 1;
        if (rx_valid && rx_ready) got_q.push_back(rx_data);
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rdy_rand = 1'($urandom_range(0, 1));
        end
    end

    typedef struct {
        logic [7:0] data;
        bit         pflip;
        bit         stop;
        int         exp_par;
        int         exp_frm;
        int         exp_push;
    } vec_t;

    vec_t vecs[7];

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    task automatic expect_pop(input string name, input logic [7:0] exp);
        checks++;
        if (got_rd >= got_q.size()) begin
            errors++;
            $display("FAIL %s: got no byte expected 0x%02h", name, exp);
        end else begin
            if (got_q[got_rd] != exp) begin
                errors++;
                $display("FAIL %s: got 0x%02h expected 0x%02h", name, got_q[got_rd], exp);
            end else begin
                $display("ok   %s = 0x%02h", name, exp);
            end
            got_rd++;
        end
    endtask

    // The frame is built from the protocol definition: start 0, data LSB
    // first, then a parity bit that makes the count of ones odd, then stop.
    function automatic logic [10:0] make_frame(input logic [7:0] d, input bit pflip, input bit stop);
        logic par;
        par = (~^d) ^ pflip;
        return {stop, par, d, 1'b0};
    endfunction

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        wait_cyc(half_cyc);
        ps2_clk = 1'b0;
        wait_cyc(half_cyc);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit pflip, input bit stop);
        logic [10:0] f;
        f = make_frame(d, pflip, stop);
        for (int b = 0; b < 11; b++) ps2_bit(f[b]);
        ps2_data = 1'b1;
        wait_cyc(half_cyc);
    endtask

    // Send a bit with a one-cycle low glitch in the high phase and a
    // one-cycle high glitch in the low phase.
    task automatic ps2_bit_glitch(input logic b);
        ps2_data = b;
        wait_cyc(8);
        ps2_clk = 1'b0;
        wait_cyc(1);
        ps2_clk = 1'b1;
        wait_cyc(12);
        ps2_clk = 1'b0;
        wait_cyc(10);
        ps2_clk = 1'b1;
        wait_cyc(1);
        ps2_clk = 1'b0;
        wait_cyc(9);
        ps2_clk = 1'b1;
    endtask

    initial begin
        int p0, f0, o0, q0, nfrm;
        logic [10:0] fr;
        logic [7:0] exp_q[$];
        int exp_par, exp_frm;

        vecs[0] = '{8'h1C, 1'b0, 1'b1, 0, 0, 1};
        vecs[1] = '{8'h1C, 1'b1, 1'b1, 1, 0, 0};
        vecs[2] = '{8'hF0, 1'b0, 1'b0, 0, 1, 0};
        vecs[3] = '{8'hF0, 1'b1, 1'b0, 0, 1, 0};
        vecs[4] = '{8'h00, 1'b0, 1'b1, 0, 0, 1};
        vecs[5] = '{8'hFF, 1'b0, 1'b1, 0, 0, 1};
        vecs[6] = '{8'hA5, 1'b1, 1'b1, 1, 0, 0};

        // ---------------- reset state ----------------
        wait_cyc(3);
        check("reset_rx_valid", int'(rx_valid), 0);
        check("reset_rx_data", int'(rx_data), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_pulses", int'({parity_err, frame_err, overflow}), 0);
        rst = 1'b1;
        wait_cyc(5);
        check("idle_busy", int'(busy), 0);

        // ---------------- test 1: 0x1C with latency ----------------
        rdy_manual = 1'b0;
        p0 = par_cnt; f0 = frm_cnt;
        fr = make_frame(8'h1C, 1'b0, 1'b1);
        check("t1_frame_parity_bit", int'(fr[9]), 0);
        for (int b = 0; b < 10; b++) begin
            ps2_bit(fr[b]);
            if (b == 4) check("t1_busy_mid", int'(busy), 1);
        end
        ps2_data = 1'b1;
        wait_cyc(half_cyc);
        ps2_clk = 1'b0;
        wait_cyc(6);
        check("t1_valid_before_latency", int'(rx_valid), 0);
        wait_cyc(1);
        check("t1_valid_at_latency", int'(rx_valid), 1);
        check("t1_rx_data", int'(rx_data), 8'h1C);
        check("t1_busy_after_stop", int'(busy), 0);
        wait_cyc(half_cyc - 7);
        ps2_clk = 1'b1;
        wait_cyc(half_cyc);
        check("t1_no_errors", (par_cnt - p0) + (frm_cnt - f0), 0);
        rdy_manual = 1'b1;
        wait_cyc(3);
        expect_pop("t1_pop", 8'h1C);
        check("t1_valid_after_pop", int'(rx_valid), 0);

        // ---------------- table-driven frames ----------------
        for (int i = 0; i < 7; i++) begin
            p0 = par_cnt; f0 = frm_cnt; q0 = got_q.size();
            send_frame(vecs[i].data, vecs[i].pflip, vecs[i].stop);
            wait_cyc(20);
            check($sformatf("vec%0d_parity_err", i), par_cnt - p0, vecs[i].exp_par);
            check($sformatf("vec%0d_frame_err", i), frm_cnt - f0, vecs[i].exp_frm);
            check($sformatf("vec%0d_push", i), got_q.size() - q0, vecs[i].exp_push);
            if (vecs[i].exp_push == 1 && got_q.size() > q0)
                check($sformatf("vec%0d_data", i), int'(got_q[q0]), int'(vecs[i].data));
            check($sformatf("vec%0d_busy", i), int'(busy), 0);
            got_rd = got_q.size();
        end

        // ---------------- test 3: bad stop then good 0xF0 ----------------
        f0 = frm_cnt; q0 = got_q.size();
        send_frame(8'hF0, 1'b0, 1'b0);
        wait_cyc(10);
        check("t3_frame_err", frm_cnt - f0, 1);
        check("t3_no_push", got_q.size() - q0, 0);
        send_frame(8'hF0, 1'b0, 1'b1);
        wait_cyc(10);
        expect_pop("t3_good_f0", 8'hF0);

        // ---------------- test 4: timeout ----------------
        f0 = frm_cnt;
        fr = make_frame(8'h1C, 1'b0, 1'b1);
        for (int b = 0; b < 5; b++) ps2_bit(fr[b]);
        wait_cyc(350);
        check("t4_busy_before_timeout", int'(busy), 1);
        check("t4_no_err_before_timeout", frm_cnt - f0, 0);
        wait_cyc(70);
        check("t4_busy_after_timeout", int'(busy), 0);
        check("t4_frame_err", frm_cnt - f0, 1);
        send_frame(8'h1C, 1'b0, 1'b1);
        wait_cyc(10);
        expect_pop("t4_recover_1c", 8'h1C);

        // ---------------- test 5: overflow ----------------
        rdy_manual = 1'b0;
        o0 = ovf_cnt;
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
        send_frame(8'h33, 1'b0, 1'b1);
        send_frame(8'h44, 1'b0, 1'b1);
        check("t5_no_ovf_at_4", ovf_cnt - o0, 0);
        check("t5_head_11", int'(rx_data), 8'h11);
        send_frame(8'h55, 1'b0, 1'b1);
        check("t5_ovf_at_5", ovf_cnt - o0, 1);
        rdy_manual = 1'b1;
        wait_cyc(10);
        expect_pop("t5_pop0", 8'h11);
        expect_pop("t5_pop1", 8'h22);
        expect_pop("t5_pop2", 8'h33);
        expect_pop("t5_pop3", 8'h44);
        check("t5_extra_pops", got_q.size() - got_rd, 0);
        check("t5_valid_after", int'(rx_valid), 0);

        // ---------------- test 6: glitches, then reset mid-frame ----------------
        p0 = par_cnt; f0 = frm_cnt;
        fr = make_frame(8'h6B, 1'b0, 1'b1);
        for (int b = 0; b < 11; b++) ps2_bit_glitch(fr[b]);
        ps2_data = 1'b1;
        wait_cyc(20);
        expect_pop("t6_glitch_byte", 8'h6B);
        check("t6_glitch_no_err", (par_cnt - p0) + (frm_cnt - f0), 0);

        rdy_manual = 1'b0;
        send_frame(8'h5A, 1'b0, 1'b1);
        check("t6_valid_before_rst", int'(rx_valid), 1);
        for (int b = 0; b < 4; b++) ps2_bit(fr[b]);
        ps2_data = 1'b0;
        ps2_clk = 1'b0;
        wait_cyc(10);
        p0 = par_cnt; f0 = frm_cnt; o0 = ovf_cnt;
        rst = 1'b0;
        wait_cyc(2);
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_valid", int'(rx_valid), 0);
        check("t6_rst_data", int'(rx_data), 0);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(3);
        rst = 1'b1;
        wait_cyc(30);
        check("t6_rst_no_pulses", (par_cnt - p0) + (frm_cnt - f0) + (ovf_cnt - o0), 0);
        check("t6_rst_still_idle", int'(busy), 0);
        got_rd = got_q.size();
        rdy_manual = 1'b1;
        send_frame(8'h1C, 1'b0, 1'b1);
        wait_cyc(10);
        expect_pop("t6_after_rst_1c", 8'h1C);

        // ---------------- randomized frames vs reference model ----------------
        p0 = par_cnt; f0 = frm_cnt; o0 = ovf_cnt;
        exp_par = 0; exp_frm = 0;
        rand_mode = 1'b1;
        nfrm = 30;
        for (int i = 0; i < nfrm; i++) begin
            logic [7:0] d;
            bit pf, st;
            d  = 8'($urandom);
            pf = ($urandom_range(0, 99) < 15);
            st = ($urandom_range(0, 99) >= 15);
            half_cyc = $urandom_range(15, 30);
            if (!st) exp_frm++;
            else if (pf) exp_par++;
            else exp_q.push_back(d);
            send_frame(d, pf, st);
            wait_cyc($urandom_range(5, 40));
        end
        half_cyc = 20;
        rand_mode = 1'b0;
        rdy_manual = 1'b1;
        wait_cyc(20);
        check("rand_parity_err", par_cnt - p0, exp_par);
        check("rand_frame_err", frm_cnt - f0, exp_frm);
        check("rand_overflow", ovf_cnt - o0, 0);
        check("rand_byte_count", got_q.size() - got_rd, exp_q.size());
        foreach (exp_q[k]) expect_pop($sformatf("rand_byte%0d", k), exp_q[k]);
        check("rand_valid_end", int'(rx_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
